// File: rtl/exe_lsu.sv
// exe_lsu: load/store unit between the execute and memory stages.
//
// Accepts one memory op at a time into an issue register, presents it on the
// bus until addr_ok, then tracks it in an in-order queue until data_ok
// returns. Misaligned ops skip the bus and enter the queue already complete
// with an address-error flag. Results leave in accept order; a flush marks
// everything in flight as cancelled so it drains silently.
//
// Ports
//   clk, reset                  clock; asynchronous active-high reset
//   flush                       cancel every in-flight op
//   in_valid/in_ready           op handshake from execute
//   in_wr, in_unsigned, in_size store select, zero-extend load, 0/1/2/3 = B/H/W/D
//   in_addr, in_wdata, in_dest  op operands
//   req, req_wr, req_size,
//   req_addr, req_wstrb,
//   req_wdata                   bus request (held until addr_ok)
//   addr_ok, data_ok, rdata     bus address accept and data return
//   out_valid/out_ready         result handshake to memory stage
//   out_data, out_dest,
//   out_ale, out_badv           result record
//   busy                        issue register or queue occupied
module exe_lsu #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_wr,
    input  logic                in_unsigned,
    input  logic [1:0]          in_size,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    input  logic [4:0]          in_dest,
    output logic                req,
    output logic                req_wr,
    output logic [1:0]          req_size,
    output logic [ADDR_W-1:0]   req_addr,
    output logic [DATA_W/8-1:0] req_wstrb,
    output logic [DATA_W-1:0]   req_wdata,
    input  logic                addr_ok,
    input  logic                data_ok,
    input  logic [DATA_W-1:0]   rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [4:0]          out_dest,
    output logic                out_ale,
    output logic [ADDR_W-1:0]   out_badv,
    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2
    } ent_st_e;

    typedef struct packed {
        ent_st_e             st;
        logic                cancel;
        logic                wr;
        logic                uns;
        logic [1:0]          size;
        logic [OFF_W-1:0]    off;
        logic [4:0]          dest;
        logic                ale;
        logic [ADDR_W-1:0]   badv;
        logic [DATA_W-1:0]   data;
    } ent_t;

    typedef struct packed {
        logic                valid;
        logic                cancel;
        logic                wr;
        logic                uns;
        logic [1:0]          size;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
        logic [STRB_W-1:0]   wstrb;
        logic [4:0]          dest;
    } iss_t;

    ent_t             q_q [DEPTH];
    ent_t             q_d [DEPTH];
    iss_t             iss_q, iss_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic              in_mis, accept, issue_fire, push, pop;
    logic [2:0]        align_mask;
    logic [15:0]       strb_full;
    logic [STRB_W-1:0] in_wstrb;
    logic [DATA_W-1:0] in_wrep;
    logic              wait_found;
    logic [PTR_W-1:0]  wait_idx, scan_idx;

    // Shift the addressed bytes down, keep the access size, then extend.
    function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] raw,
                                                   input logic [OFF_W-1:0]  off,
                                                   input logic [1:0]        size,
                                                   input logic              uns);
        logic [DATA_W-1:0] sh, keep;
        logic              sign;
        sh = raw >> {off, 3'b000};
        case (size)
            2'd0:    begin keep = DATA_W'(8'hFF);        sign = sh[7];        end
            2'd1:    begin keep = DATA_W'(16'hFFFF);     sign = sh[15];       end
            2'd2:    begin keep = DATA_W'(32'hFFFF_FFFF); sign = sh[31];       end
            default: begin keep = '1;                    sign = sh[DATA_W-1]; end
        endcase
        return (sh & keep) | ((sign && !uns) ? ~keep : '0);
    endfunction

    // Decode of the incoming op: alignment, byte strobes, lane replication.
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        align_mask = 3'b000;
        case (in_size)
            2'd0:    align_mask = 3'b000;
            2'd1:    align_mask = 3'b001;
            2'd2:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
        // A doubleword cannot be carried by a 32-bit data path at all.
        in_mis = (|(in_addr[2:0] & align_mask)) || ((in_size == 2'd3) && (DATA_W < 64));

        strb_full = (16'd1 << (5'd1 << in_size)) - 16'd1;
        strb_full = strb_full << in_addr[OFF_W-1:0];
        in_wstrb  = strb_full[STRB_W-1:0];

        in_wrep = '0;
        for (int b = 0; b < STRB_W; b++) begin
            in_wrep[8*b +: 8] = in_wdata[8*(b & ((1 << in_size) - 1)) +: 8];
        end
    end

    assign in_ready   = !flush && !iss_q.valid && (cnt_q < CNT_W'(DEPTH));
    assign accept     = in_valid && in_ready;
    assign issue_fire = iss_q.valid && addr_ok;
    assign push       = (accept && in_mis) || issue_fire;
    // A cancelled result is dropped as soon as it is DONE at the head.
    assign pop        = (q_q[head_q].st == ST_DONE) && (q_q[head_q].cancel || out_ready);

    // Next-state for issue register and queue.
    always_comb begin
        q_d    = q_q;
        iss_d  = iss_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);

        // Oldest WAIT entry, scanning from the head in queue order.
        wait_found = 1'b0;
        wait_idx   = head_q;
        scan_idx   = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PTR_W'(i);
            if (!wait_found && (q_q[scan_idx].st == ST_WAIT)) begin
                wait_found = 1'b1;
                wait_idx   = scan_idx;
            end
        end

        // data_ok with nothing waiting is a stale response and is dropped.
        if (data_ok && wait_found) begin
            q_d[wait_idx].st   = ST_DONE;
            q_d[wait_idx].data = q_q[wait_idx].wr ? '0
                               : load_ext(rdata, q_q[wait_idx].off, q_q[wait_idx].size,
                                          q_q[wait_idx].uns);
        end

        if (pop) begin
            q_d[head_q] = '0;
            head_d      = head_q + PTR_W'(1);
        end

        // Push and pop never target the same slot: a push needs a free slot,
        // a pop needs an occupied head.
        if (push) begin
            q_d[tail_q] = '0;
            if (issue_fire) begin
                q_d[tail_q].st     = ST_WAIT;
                q_d[tail_q].cancel = iss_q.cancel;
                q_d[tail_q].wr     = iss_q.wr;
                q_d[tail_q].uns    = iss_q.uns;
                q_d[tail_q].size   = iss_q.size;
                q_d[tail_q].off    = iss_q.addr[OFF_W-1:0];
                q_d[tail_q].dest   = iss_q.dest;
            end else begin
                q_d[tail_q].st   = ST_DONE;
                q_d[tail_q].dest = in_dest;
                q_d[tail_q].ale  = 1'b1;
                q_d[tail_q].badv = in_addr;
            end
            tail_d = tail_q + PTR_W'(1);
        end

        if (accept && !in_mis) begin
            iss_d.valid  = 1'b1;
            iss_d.cancel = 1'b0;
            iss_d.wr     = in_wr;
            iss_d.uns    = in_unsigned;
            iss_d.size   = in_size;
            iss_d.addr   = in_addr;
            iss_d.wdata  = in_wrep;
            iss_d.wstrb  = in_wstrb;
            iss_d.dest   = in_dest;
        end else if (issue_fire) begin
            // Only the valid/cancel bits drop; the request fields stay put.
            iss_d.valid  = 1'b0;
            iss_d.cancel = 1'b0;
        end

        // Flush only tags ops; bus fields are untouched so req_* stay stable.
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q_d[i].st != ST_EMPTY) q_d[i].cancel = 1'b1;
            end
            if (iss_d.valid) iss_d.cancel = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments only; the queue is
    // small and fully reset so its outputs read zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q    <= '{default: '0};
            iss_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            q_q    <= q_d;
            iss_q  <= iss_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign req       = iss_q.valid;
    assign req_wr    = iss_q.wr;
    assign req_size  = iss_q.size;
    assign req_addr  = iss_q.addr;
    assign req_wstrb = iss_q.wstrb;
    assign req_wdata = iss_q.wdata;

    assign out_valid = (q_q[head_q].st == ST_DONE) && !q_q[head_q].cancel;
    assign out_data  = q_q[head_q].data;
    assign out_dest  = q_q[head_q].dest;
    assign out_ale   = q_q[head_q].ale;
    assign out_badv  = q_q[head_q].badv;
    assign busy      = iss_q.valid || (cnt_q != '0);

endmodule

// File: tb/tb_exe_lsu.sv
// Directed bench for exe_lsu: a 32-bit instance (DEPTH=2) for the main
// scenarios and a 64-bit instance for doubleword and wide-lane accesses.
module tb_exe_lsu;

    logic        clk;
    logic        reset;

    // 32-bit instance
    logic        flush, in_valid, in_ready, in_wr, in_unsigned;
    logic [1:0]  in_size;
    logic [31:0] in_addr, in_wdata;
    logic [4:0]  in_dest;
    logic        req, req_wr;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;
    logic        out_valid, out_ready, out_ale, busy;
    logic [31:0] out_data, out_badv;
    logic [4:0]  out_dest;

    // 64-bit instance
    logic        w_flush, w_in_valid, w_in_ready, w_in_wr, w_in_unsigned;
    logic [1:0]  w_in_size;
    logic [31:0] w_in_addr;
    logic [63:0] w_in_wdata;
    logic [4:0]  w_in_dest;
    logic        w_req, w_req_wr;
    logic [1:0]  w_req_size;
    logic [31:0] w_req_addr;
    logic [63:0] w_req_wdata;
    logic [7:0]  w_req_wstrb;
    logic        w_addr_ok, w_data_ok;
    logic [63:0] w_rdata;
    logic        w_out_valid, w_out_ready, w_out_ale, w_busy;
    logic [63:0] w_out_data;
    logic [31:0] w_out_badv;
    logic [4:0]  w_out_dest;

    int n_cmp  = 0;
    int n_fail = 0;

    exe_lsu #(.DATA_W(32), .ADDR_W(32), .DEPTH(2)) u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_wr(in_wr), .in_unsigned(in_unsigned),
        .in_size(in_size), .in_addr(in_addr), .in_wdata(in_wdata), .in_dest(in_dest),
        .req(req), .req_wr(req_wr), .req_size(req_size), .req_addr(req_addr),
        .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_dest(out_dest), .out_ale(out_ale), .out_badv(out_badv), .busy(busy)
    );

    exe_lsu #(.DATA_W(64), .ADDR_W(32), .DEPTH(2)) u_dut64 (
        .clk(clk), .reset(reset), .flush(w_flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_wr(w_in_wr),
        .in_unsigned(w_in_unsigned), .in_size(w_in_size), .in_addr(w_in_addr),
        .in_wdata(w_in_wdata), .in_dest(w_in_dest),
        .req(w_req), .req_wr(w_req_wr), .req_size(w_req_size), .req_addr(w_req_addr),
        .req_wstrb(w_req_wstrb), .req_wdata(w_req_wdata),
        .addr_ok(w_addr_ok), .data_ok(w_data_ok), .rdata(w_rdata),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
        .out_dest(w_out_dest), .out_ale(w_out_ale), .out_badv(w_out_badv), .busy(w_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single accept cycle; returns in the cycle after accept.
    task automatic op(input logic wr, input logic uns, input logic [1:0] size,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] dest);
        in_wr       = wr;
        in_unsigned = uns;
        in_size     = size;
        in_addr     = addr;
        in_wdata    = wdata;
        in_dest     = dest;
        in_valid    = 1'b1;
        #1;
        check("accept_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    // addr_ok in the current cycle, data_ok with rd in the next one.
    task automatic bus(input logic [31:0] rd);
        addr_ok = 1'b1;
        step();
        addr_ok = 1'b0;
        data_ok = 1'b1;
        rdata   = rd;
        step();
        data_ok = 1'b0;
    endtask

    task automatic load_chk(input string tag, input logic uns, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] rd,
                            input logic [31:0] exp);
        op(1'b0, uns, size, addr, 32'h0, 5'd9);
        check({tag, "_req"}, req, 1);
        bus(rd);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, exp);
        check({tag, "_ale"}, out_ale, 0);
        step();
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0; in_valid = 1'b0; in_wr = 1'b0; in_unsigned = 1'b0;
        in_size = 2'd0; in_addr = '0; in_wdata = '0; in_dest = '0;
        addr_ok = 1'b0; data_ok = 1'b0; rdata = '0; out_ready = 1'b1;
        w_flush = 1'b0; w_in_valid = 1'b0; w_in_wr = 1'b0; w_in_unsigned = 1'b0;
        w_in_size = 2'd0; w_in_addr = '0; w_in_wdata = '0; w_in_dest = '0;
        w_addr_ok = 1'b0; w_data_ok = 1'b0; w_rdata = '0; w_out_ready = 1'b1;

        // Reset state
        step();
        step();
        check("rst_in_ready", in_ready, 1);
        check("rst_req", req, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_req_addr", req_addr, 0);
        check("rst_out_data", out_data, 0);
        reset = 1'b0;

        // LW 0x1004: req at cycle 1, addr_ok there, data_ok at 2, result at 3
        op(1'b0, 1'b0, 2'd2, 32'h0000_1004, 32'h0, 5'd5);
        check("lw_req", req, 1);
        check("lw_req_addr", req_addr, 32'h0000_1004);
        check("lw_req_size", req_size, 2);
        check("lw_req_wr", req_wr, 0);
        check("lw_busy", busy, 1);
        check("lw_in_ready", in_ready, 0);
        addr_ok = 1'b1;
        step();
        addr_ok = 1'b0;
        check("lw_c2_req", req, 0);
        check("lw_c2_valid", out_valid, 0);
        data_ok = 1'b1;
        rdata   = 32'h8899_AABB;
        step();
        data_ok = 1'b0;
        check("lw_c3_valid", out_valid, 1);
        check("lw_data", out_data, 32'h8899_AABB);
        check("lw_dest", out_dest, 5);
        check("lw_ale", out_ale, 0);
        step();
        check("lw_popped", out_valid, 0);
        check("lw_idle", busy, 0);

        // Sub-word loads and extension
        load_chk("lb", 1'b0, 2'd0, 32'h0000_1003, 32'h8000_0000, 32'hFFFF_FF80);
        load_chk("lbu", 1'b1, 2'd0, 32'h0000_1003, 32'h8000_0000, 32'h0000_0080);
        load_chk("lh", 1'b0, 2'd1, 32'h0000_1002, 32'h8000_0000, 32'hFFFF_8000);
        load_chk("lhu", 1'b1, 2'd1, 32'h0000_1000, 32'h1234_ABCD, 32'h0000_ABCD);

        // Stores: strobes and lane replication, store result data is 0
        op(1'b1, 1'b0, 2'd1, 32'h0000_2002, 32'h0000_1234, 5'd4);
        check("sh_req_wr", req_wr, 1);
        check("sh_wstrb", req_wstrb, 4'b1100);
        check("sh_wdata", req_wdata, 32'h1234_1234);
        bus(32'hDEAD_BEEF);
        check("sh_valid", out_valid, 1);
        check("sh_data", out_data, 0);
        step();
        op(1'b1, 1'b0, 2'd0, 32'h0000_2001, 32'h0000_00AB, 5'd4);
        check("sb_wstrb", req_wstrb, 4'b0010);
        check("sb_wdata", req_wdata, 32'hABAB_ABAB);
        bus(32'h0);
        step();

        // Misaligned ops bypass the bus
        op(1'b0, 1'b0, 2'd2, 32'h0000_2002, 32'h0, 5'd6);
        check("ale_req", req, 0);
        check("ale_valid", out_valid, 1);
        check("ale_flag", out_ale, 1);
        check("ale_badv", out_badv, 32'h0000_2002);
        check("ale_dest", out_dest, 6);
        step();
        check("ale_idle", busy, 0);
        op(1'b0, 1'b0, 2'd3, 32'h0000_1008, 32'h0, 5'd6);
        check("ld32_req", req, 0);
        check("ld32_ale", out_ale, 1);
        check("ld32_badv", out_badv, 32'h0000_1008);
        step();

        // Queue full with data_ok withheld, then in-order drain
        out_ready = 1'b0;
        op(1'b0, 1'b0, 2'd2, 32'h0000_3000, 32'h0, 5'd1);
        addr_ok = 1'b1;
        step();
        addr_ok = 1'b0;
        op(1'b0, 1'b0, 2'd2, 32'h0000_3004, 32'h0, 5'd2);
        addr_ok = 1'b1;
        step();
        addr_ok = 1'b0;
        in_addr  = 32'h0000_3008;
        in_dest  = 5'd3;
        in_valid = 1'b1;
        #1;
        check("full_in_ready", in_ready, 0);
        check("full_busy", busy, 1);
        data_ok = 1'b1;
        rdata   = 32'h1111_1111;
        step();
        data_ok = 1'b0;
        check("q_a_valid", out_valid, 1);
        check("q_a_data", out_data, 32'h1111_1111);
        check("q_a_dest", out_dest, 1);
        check("q_a_full", in_ready, 0);
        out_ready = 1'b1;
        step();
        check("q_space", in_ready, 1);
        check("q_b_wait", out_valid, 0);
        step();
        in_valid = 1'b0;
        check("q_c_req", req, 1);
        check("q_c_addr", req_addr, 32'h0000_3008);
        addr_ok = 1'b1;
        data_ok = 1'b1;
        rdata   = 32'h2222_2222;
        step();
        addr_ok = 1'b0;
        rdata   = 32'h3333_3333;
        check("q_b_data", out_data, 32'h2222_2222);
        check("q_b_dest", out_dest, 2);
        check("q_b_valid", out_valid, 1);
        step();
        data_ok = 1'b0;
        check("q_c_valid", out_valid, 1);
        check("q_c_data", out_data, 32'h3333_3333);
        check("q_c_dest", out_dest, 3);
        step();
        check("q_idle", busy, 0);
        data_ok = 1'b1;
        step();
        data_ok = 1'b0;
        check("stray_dok_busy", busy, 0);
        check("stray_dok_valid", out_valid, 0);

        // Flush while the request waits for addr_ok
        op(1'b0, 1'b0, 2'd2, 32'h0000_4000, 32'h0, 5'd7);
        flush = 1'b1;
        #1;
        check("fl_in_ready", in_ready, 0);
        step();
        flush = 1'b0;
        check("fl_req_hold", req, 1);
        check("fl_addr_hold", req_addr, 32'h0000_4000);
        step();
        check("fl_size_hold", req_size, 2);
        check("fl_req_hold2", req, 1);
        bus(32'h5555_5555);
        check("fl_no_valid", out_valid, 0);
        step();
        check("fl_no_valid2", out_valid, 0);
        check("fl_idle", busy, 0);

        // Flush of a completed but unconsumed result
        out_ready = 1'b0;
        op(1'b0, 1'b0, 2'd2, 32'h0000_4002, 32'h0, 5'd8);
        check("fd_valid", out_valid, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fd_cancel", out_valid, 0);
        step();
        check("fd_idle", busy, 0);
        out_ready = 1'b1;

        // Reset in the middle of a request; late response ignored
        op(1'b0, 1'b0, 2'd2, 32'h0000_5000, 32'h0, 5'd9);
        reset = 1'b1;
        #1;
        check("mid_rst_req", req, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr", req_addr, 0);
        step();
        reset   = 1'b0;
        data_ok = 1'b1;
        step();
        data_ok = 1'b0;
        check("post_rst_valid", out_valid, 0);
        check("post_rst_busy", busy, 0);

        // 64-bit data path: LD at 0x1008
        w_in_size = 2'd3; w_in_addr = 32'h0000_1008; w_in_wr = 1'b0; w_in_valid = 1'b1;
        #1;
        check("w_ld_ready", w_in_ready, 1);
        step();
        w_in_valid = 1'b0;
        check("w_ld_req", w_req, 1);
        check("w_ld_size", w_req_size, 3);
        check("w_ld_addr", w_req_addr, 32'h0000_1008);
        w_addr_ok = 1'b1;
        step();
        w_addr_ok = 1'b0;
        w_data_ok = 1'b1;
        w_rdata   = 64'h0123_4567_89AB_CDEF;
        step();
        w_data_ok = 1'b0;
        check("w_ld_valid", w_out_valid, 1);
        check("w_ld_data", w_out_data, 64'h0123_4567_89AB_CDEF);
        check("w_ld_ale", w_out_ale, 0);
        step();

        // 64-bit: LW in upper lane, sign-extended to 64 bits
        w_in_size = 2'd2; w_in_addr = 32'h0000_100C; w_in_valid = 1'b1;
        step();
        w_in_valid = 1'b0;
        w_addr_ok  = 1'b1;
        step();
        w_addr_ok = 1'b0;
        w_data_ok = 1'b1;
        w_rdata   = 64'h8000_0000_1111_1111;
        step();
        w_data_ok = 1'b0;
        check("w_lw_data", w_out_data, 64'hFFFF_FFFF_8000_0000);
        step();

        // 64-bit: SW at 0x1004
        w_in_wr = 1'b1; w_in_size = 2'd2; w_in_addr = 32'h0000_1004;
        w_in_wdata = 64'h0000_0000_CAFE_BABE; w_in_valid = 1'b1;
        step();
        w_in_valid = 1'b0;
        check("w_sw_wstrb", w_req_wstrb, 8'hF0);
        check("w_sw_wdata", w_req_wdata, 64'hCAFE_BABE_CAFE_BABE);
        w_addr_ok = 1'b1;
        step();
        w_addr_ok = 1'b0;
        w_data_ok = 1'b1;
        step();
        w_data_ok = 1'b0;
        check("w_sw_data", w_out_data, 0);
        step();
        check("w_idle", w_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
